// File: rtl/isr_ctrl.sv
// In-Service Register controller for an 8259A-style PIC: tracks serviced IR levels,
// applies non-specific/specific/automatic EOI and maintains the rotating-priority base.
module isr_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int LVL_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ack_valid,
  input  logic [LVL_W-1:0]   ack_level,
  input  logic               ack_done,
  input  logic               aeoi_en,
  input  logic               aeoi_rotate,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [LVL_W-1:0]   eoi_level,
  input  logic               setprio_valid,
  input  logic [LVL_W-1:0]   setprio_level,
  output logic [NUM_IRQ-1:0] isr,
  output logic               isr_hi_valid,
  output logic [LVL_W-1:0]   isr_hi_level,
  output logic [LVL_W-1:0]   lowest_prio,
  output logic               ack_dup_err
);

  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_IRQ - 1);
  localparam logic [LVL_W:0]   NUM_EXT  = (LVL_W + 1)'(NUM_IRQ);

  // Levels at or above NUM_IRQ decode to an empty mask, so they never touch the ISR.
  function automatic logic [NUM_IRQ-1:0] lvl_mask(input logic [LVL_W-1:0] lvl);
    lvl_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (lvl == LVL_W'(i)) lvl_mask[i] = 1'b1;
    end
  endfunction

  logic               aeoi_pend;
  logic [LVL_W-1:0]   aeoi_lvl;

  logic               ack_in, eoi_in, setprio_in;
  logic               ns_fire, sp_fire, aeoi_fire;
  logic [NUM_IRQ-1:0] ack_mask, clr_mask, isr_nxt;
  logic [LVL_W-1:0]   low_nxt;
  logic               dup_hit;

  // Scan from lowest priority (offset NUM_IRQ) up to highest (offset 1); the last hit wins.
  always_comb begin
    isr_hi_valid = 1'b0;
    isr_hi_level = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (isr[i] && ((int'(lowest_prio) + k == i) ||
                       (int'(lowest_prio) + k == i + NUM_IRQ))) begin
          isr_hi_valid = 1'b1;
          isr_hi_level = LVL_W'(i);
        end
      end
    end
  end

  always_comb begin
    ack_in     = {1'b0, ack_level} < NUM_EXT;
    eoi_in     = {1'b0, eoi_level} < NUM_EXT;
    setprio_in = {1'b0, setprio_level} < NUM_EXT;

    ns_fire   = eoi_valid && !eoi_specific && isr_hi_valid;
    sp_fire   = eoi_valid && eoi_specific && eoi_in;
    aeoi_fire = ack_done && aeoi_en && aeoi_pend;

    ack_mask = ack_valid ? lvl_mask(ack_level) : '0;
    clr_mask = '0;
    if (ns_fire)   clr_mask = clr_mask | lvl_mask(isr_hi_level);
    if (sp_fire)   clr_mask = clr_mask | lvl_mask(eoi_level);
    if (aeoi_fire) clr_mask = clr_mask | lvl_mask(aeoi_lvl);

    // Clears use the pre-edge ISR; a same-cycle acknowledge re-sets its bit.
    isr_nxt = (isr & ~clr_mask) | ack_mask;
    dup_hit = |(isr & ack_mask);

    // Later assignments take precedence: EOI rotate > set-priority > AEOI rotate.
    low_nxt = lowest_prio;
    if (aeoi_fire && aeoi_rotate)                 low_nxt = aeoi_lvl;
    if (setprio_valid && !eoi_valid && setprio_in) low_nxt = setprio_level;
    if (ns_fire && eoi_rotate)                    low_nxt = isr_hi_level;
    if (sp_fire && eoi_rotate)                    low_nxt = eoi_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isr         <= '0;
      lowest_prio <= LAST_LVL;
      ack_dup_err <= 1'b0;
      aeoi_pend   <= 1'b0;
      aeoi_lvl    <= '0;
    end else begin
      isr         <= isr_nxt;
      lowest_prio <= low_nxt;
      if (dup_hit) ack_dup_err <= 1'b1;
      if (ack_valid && ack_in) begin
        aeoi_pend <= 1'b1;
        aeoi_lvl  <= ack_level;
      end else if (ack_done) begin
        aeoi_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_isr_ctrl.sv
// Bench for isr_ctrl: an 8-level and a 5-level instance share stimulus and are
// compared each cycle against an integer reference model of the PIC ISR rules.
module tb_isr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack_valid = 0, ack_done = 0, aeoi_en = 0, aeoi_rotate = 0;
  logic       eoi_valid = 0, eoi_specific = 0, eoi_rotate = 0, setprio_valid = 0;
  logic [2:0] ack_level = 0, eoi_level = 0, setprio_level = 0;

  logic [7:0] isr8;
  logic [4:0] isr5;
  logic       hv8, hv5, err8, err5;
  logic [2:0] hl8, hl5, low8, low5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  isr_ctrl #(.NUM_IRQ(8), .LVL_W(3)) dut8 (
    .clk(clk), .rst(rst), .ack_valid(ack_valid), .ack_level(ack_level), .ack_done(ack_done),
    .aeoi_en(aeoi_en), .aeoi_rotate(aeoi_rotate), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .setprio_valid(setprio_valid), .setprio_level(setprio_level),
    .isr(isr8), .isr_hi_valid(hv8), .isr_hi_level(hl8), .lowest_prio(low8), .ack_dup_err(err8));

  isr_ctrl #(.NUM_IRQ(5), .LVL_W(3)) dut5 (
    .clk(clk), .rst(rst), .ack_valid(ack_valid), .ack_level(ack_level), .ack_done(ack_done),
    .aeoi_en(aeoi_en), .aeoi_rotate(aeoi_rotate), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .setprio_valid(setprio_valid), .setprio_level(setprio_level),
    .isr(isr5), .isr_hi_valid(hv5), .isr_hi_level(hl5), .lowest_prio(low5), .ack_dup_err(err5));

  // Reference model state, index 0 = 8-level instance, 1 = 5-level instance.
  int nn [2] = '{8, 5};
  int m_isr [2], m_low [2], m_plvl [2];
  bit m_err [2], m_pend [2];

  function automatic void model_hi(input int idx, output bit v, output int lvl);
    v = 0;
    lvl = 0;
    for (int off = 1; off <= nn[idx]; off++) begin
      int l = (m_low[idx] + off) % nn[idx];
      if (!v && ((m_isr[idx] >> l) & 1) == 1) begin
        v = 1;
        lvl = l;
      end
    end
  endfunction

  task automatic model_step(input int idx);
    int n = nn[idx];
    int nisr, nlow, hl;
    bit hv;
    if (rst) begin
      m_isr[idx] = 0; m_low[idx] = n - 1; m_err[idx] = 0; m_pend[idx] = 0; m_plvl[idx] = 0;
      return;
    end
    model_hi(idx, hv, hl);
    nisr = m_isr[idx];
    nlow = m_low[idx];
    if (aeoi_en && ack_done && m_pend[idx]) begin
      nisr &= ~(1 << m_plvl[idx]);
      if (aeoi_rotate) nlow = m_plvl[idx];
    end
    if (!eoi_valid && setprio_valid && setprio_level < n) nlow = setprio_level;
    if (eoi_valid && !eoi_specific && hv) begin
      nisr &= ~(1 << hl);
      if (eoi_rotate) nlow = hl;
    end
    if (eoi_valid && eoi_specific && eoi_level < n) begin
      nisr &= ~(1 << eoi_level);
      if (eoi_rotate) nlow = eoi_level;
    end
    if (ack_valid && ack_level < n) begin
      if (((m_isr[idx] >> ack_level) & 1) == 1) m_err[idx] = 1;
      nisr |= (1 << ack_level);
      m_pend[idx] = 1;
      m_plvl[idx] = ack_level;
    end else if (ack_done) begin
      m_pend[idx] = 0;
    end
    m_isr[idx] = nisr;
    m_low[idx] = nlow;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit v;
    int l;
    model_hi(0, v, l);
    chk("isr8", 32'(isr8), m_isr[0]);
    chk("hv8", 32'(hv8), 32'(v));
    chk("hl8", 32'(hl8), l);
    chk("low8", 32'(low8), m_low[0]);
    chk("err8", 32'(err8), 32'(m_err[0]));
    model_hi(1, v, l);
    chk("isr5", 32'(isr5), m_isr[1]);
    chk("hv5", 32'(hv5), 32'(v));
    chk("hl5", 32'(hl5), l);
    chk("low5", 32'(low5), m_low[1]);
    chk("err5", 32'(err5), 32'(m_err[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; ack_valid = 0; ack_done = 0; eoi_valid = 0; eoi_specific = 0;
    eoi_rotate = 0; setprio_valid = 0;
  endtask

  task automatic do_ack(input int lvl);
    idle(); ack_valid = 1; ack_level = 3'(lvl); tick(); idle();
  endtask

  task automatic do_eoi(input bit spec, input bit rot, input int lvl);
    idle(); eoi_valid = 1; eoi_specific = spec; eoi_rotate = rot; eoi_level = 3'(lvl);
    tick(); idle();
  endtask

  task automatic do_rst();
    idle(); rst = 1; tick(); idle();
  endtask

  initial begin
    // Reset with strobes active
    rst = 1; ack_valid = 1; ack_level = 3; eoi_valid = 1; ack_done = 1;
    tick();
    chk("rst_isr8", 32'(isr8), 32'h00);
    chk("rst_low8", 32'(low8), 32'd7);
    chk("rst_low5", 32'(low5), 32'd4);
    idle();

    // Fully nested ack/EOI
    do_ack(5);
    chk("nest_isr_a", 32'(isr8), 32'h20);
    do_ack(2);
    chk("nest_isr_b", 32'(isr8), 32'h24);
    chk("nest_hl_b", 32'(hl8), 32'd2);
    do_eoi(0, 0, 0);
    chk("nest_isr_c", 32'(isr8), 32'h20);
    chk("nest_hl_c", 32'(hl8), 32'd5);
    do_rst();

    // Rotating non-specific EOI
    setprio_valid = 1; setprio_level = 3; tick(); idle();
    do_ack(2);
    do_ack(5);
    do_eoi(0, 1, 0);
    chk("rot_isr", 32'(isr8), 32'h04);
    chk("rot_low", 32'(low8), 32'd5);
    do_rst();

    // AEOI with rotation
    aeoi_en = 1; aeoi_rotate = 1;
    do_ack(6);
    chk("aeoi_isr_a", 32'(isr8), 32'h40);
    ack_done = 1; tick(); idle();
    chk("aeoi_isr_b", 32'(isr8), 32'h00);
    chk("aeoi_low", 32'(low8), 32'd6);
    aeoi_en = 0; aeoi_rotate = 0;
    do_rst();

    // Set wins over same-cycle specific EOI, then duplicate ack
    do_ack(3);
    eoi_valid = 1; eoi_specific = 1; eoi_level = 3; ack_valid = 1; ack_level = 3;
    tick(); idle();
    chk("setwin_isr", 32'(isr8), 32'h08);
    do_ack(3);
    chk("dup_err", 32'(err8), 32'd1);
    do_rst();

    // 5-level boundary behaviour
    do_ack(6);
    chk("n5_oor_isr", 32'(isr5), 32'h00);
    chk("n5_oor_err", 32'(err5), 32'd0);
    setprio_valid = 1; setprio_level = 4; tick(); idle();
    do_ack(0);
    do_ack(4);
    chk("n5_hl", 32'(hl5), 32'd0);
    do_eoi(0, 1, 0);
    chk("n5_isr", 32'(isr5), 32'h10);
    chk("n5_low", 32'(low5), 32'd0);
    do_rst();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      ack_valid     = ($urandom_range(0, 2) == 0);
      ack_level     = 3'($urandom_range(0, 7));
      ack_done      = ($urandom_range(0, 2) == 0);
      aeoi_en       = ($urandom_range(0, 1) == 0);
      aeoi_rotate   = ($urandom_range(0, 1) == 0);
      eoi_valid     = ($urandom_range(0, 3) == 0);
      eoi_specific  = ($urandom_range(0, 1) == 0);
      eoi_rotate    = ($urandom_range(0, 1) == 0);
      eoi_level     = 3'($urandom_range(0, 7));
      setprio_valid = ($urandom_range(0, 5) == 0);
      setprio_level = 3'($urandom_range(0, 7));
      tick();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
